// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - grid snake game engine: occupancy state, step FSM, collision/food logic and pixel renderer
//
// Ports:
//   vga_clock                    sole clock
//   rst_n                        synchronous active-low reset
//   tick                         one-cycle step request (dropped while busy)
//   up_in/down_in/left_in/right_in  synchronised direction buttons
//   screenX, screenY             current pixel position from the VGA timing generator
//   r, g, b                      registered 4-bit pixel colour, one cycle after screenX/screenY
//   dead                         high while the game is over
//   busy                         high while a step is being processed
//   score                        food eaten since reset/restart, saturating
module snake_engine #(
    parameter int GRID_W    = 30,
    parameter int GRID_H    = 22,
    parameter int CELL_LOG2 = 4,
    parameter int BORDER_X  = 80,
    parameter int BORDER_Y  = 64,
    parameter int LEN_W     = 10,
    parameter int INIT_LEN  = 5
) (
    input  logic       vga_clock,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       up_in,
    input  logic       down_in,
    input  logic       left_in,
    input  logic       right_in,
    input  logic [9:0] screenX,
    input  logic [8:0] screenY,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       dead,
    output logic       busy,
    output logic [7:0] score
);

    localparam int N          = GRID_W * GRID_H;
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1;
    localparam int CENTER_IDX = (GRID_H / 2) * GRID_W + GRID_W / 2;

    localparam logic [4:0]       INIT_X     = 5'(GRID_W / 2);
    localparam logic [4:0]       INIT_Y     = 5'(GRID_H / 2);
    localparam logic [4:0]       FOOD0_X    = 5'(GRID_W / 4);
    localparam logic [4:0]       FOOD0_Y    = 5'(GRID_H / 4);
    localparam logic [LEN_W-1:0] INIT_LEN_V = LEN_W'(INIT_LEN);
    localparam logic [5:0]       GW6        = 6'(GRID_W);
    localparam logic [5:0]       GH6        = 6'(GRID_H);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
    localparam logic [9:0]       BX         = 10'(BORDER_X);
    localparam logic [8:0]       BY         = 9'(BORDER_Y);
    localparam logic [10:0]      PF_W       = 11'(GRID_W << CELL_LOG2);
    localparam logic [10:0]      PF_H       = 11'(GRID_H << CELL_LOG2);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SWEEP, S_HEAD, S_FOOD, S_DEAD} state_t;
    typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN} dir_t;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_RIGHT: opposite = DIR_LEFT;
            DIR_LEFT:  opposite = DIR_RIGHT;
            DIR_UP:    opposite = DIR_DOWN;
            default:   opposite = DIR_UP;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q [N];
    logic [LEN_W-1:0] cnt_d [N];
    logic [4:0]       head_x_q, head_x_d, head_y_q, head_y_d;
    dir_t             dir_q, dir_d;
    logic [LEN_W-1:0] length_q, length_d;
    logic [4:0]       food_x_q, food_x_d, food_y_q, food_y_d;
    logic             food_valid_q, food_valid_d;
    logic [7:0]       score_q, score_d;
    logic             eat_q, eat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [3:0]       r_q, r_d, g_q, g_d, b_q, b_d;

    logic [5:0]       next_x, next_y;
    logic             next_out;
    logic [IDX_W-1:0] next_idx;
    logic [LEN_W-1:0] next_cnt;
    logic [LEN_W-1:0] grown;
    dir_t             req_dir;
    logic             req_valid;
    logic             any_btn;
    logic             restart;

    // Candidate head cell; 0-1 wraps to 63, which the range test treats as outside.
    always_comb begin
        next_x = {1'b0, head_x_q};
        next_y = {1'b0, head_y_q};
        case (dir_q)
            DIR_RIGHT: next_x = {1'b0, head_x_q} + 6'd1;
            DIR_LEFT:  next_x = {1'b0, head_x_q} - 6'd1;
            DIR_UP:    next_y = {1'b0, head_y_q} - 6'd1;
            default:   next_y = {1'b0, head_y_q} + 6'd1;
        endcase
    end

    assign next_out = (next_x >= GW6) || (next_y >= GH6);
    assign next_idx = IDX_W'(32'(next_y) * GRID_W + 32'(next_x));
    assign next_cnt = next_out ? '0 : cnt_q[next_idx];
    assign grown    = (length_q == '1) ? length_q : length_q + LEN_W'(1);
    assign any_btn  = up_in | down_in | left_in | right_in;

    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_RIGHT;
        if (up_in)         req_dir = DIR_UP;
        else if (down_in)  req_dir = DIR_DOWN;
        else if (left_in)  req_dir = DIR_LEFT;
        else if (right_in) req_dir = DIR_RIGHT;
        else               req_valid = 1'b0;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        head_x_d     = head_x_q;
        head_y_d     = head_y_q;
        dir_d        = dir_q;
        length_d     = length_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        score_d      = score_q;
        eat_d        = eat_q;
        idx_d        = idx_q;
        scan_cnt_d   = scan_cnt_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        restart      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    if (req_valid && (req_dir != opposite(dir_q))) dir_d = req_dir;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // A counter of 1 is the tail, which leaves during this same step.
                if (next_out || (next_cnt > LEN_W'(1))) begin
                    state_d = S_DEAD;
                end else begin
                    eat_d   = food_valid_q && (next_x == {1'b0, food_x_q}) && (next_y == {1'b0, food_y_q});
                    idx_d   = '0;
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (cnt_q[idx_q] != '0) cnt_d[idx_q] = cnt_q[idx_q] - LEN_W'(1);
                if (idx_q == LAST_IDX) state_d = S_HEAD;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            S_HEAD: begin
                head_x_d = next_x[4:0];
                head_y_d = next_y[4:0];
                if (eat_q) begin
                    cnt_d[next_idx] = grown;
                    length_d        = grown;
                    score_d         = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    food_valid_d    = 1'b0;
                    idx_d           = IDX_W'(lfsr_q % N);
                    scan_cnt_d      = '0;
                    state_d         = S_FOOD;
                end else begin
                    cnt_d[next_idx] = length_q;
                    state_d         = S_IDLE;
                end
            end
            S_FOOD: begin
                if (cnt_q[idx_q] == '0) begin
                    food_x_d     = 5'(idx_q % GRID_W);
                    food_y_d     = 5'(idx_q / GRID_W);
                    food_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end else if (scan_cnt_q == LAST_IDX) begin
                    // Every cell occupied: leave without food.
                    state_d = S_IDLE;
                end else begin
                    idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                    scan_cnt_d = scan_cnt_q + IDX_W'(1);
                end
            end
            S_DEAD: begin
                if (tick && any_btn) restart = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (restart) begin
            for (int i = 0; i < N; i++) cnt_d[i] = (i == CENTER_IDX) ? INIT_LEN_V : '0;
            head_x_d     = INIT_X;
            head_y_d     = INIT_Y;
            dir_d        = DIR_RIGHT;
            length_d     = INIT_LEN_V;
            food_x_d     = FOOD0_X;
            food_y_d     = FOOD0_Y;
            food_valid_d = 1'b1;
            score_d      = 8'd0;
            eat_d        = 1'b0;
            idx_d        = '0;
            scan_cnt_d   = '0;
            state_d      = S_IDLE;
        end
    end

    logic [10:0]      px_off, py_off;
    logic [4:0]       cx, cy;
    logic             in_pf;
    logic [IDX_W-1:0] rend_idx;
    logic [LEN_W-1:0] rend_cnt;

    always_comb begin
        px_off   = {1'b0, screenX} - {1'b0, BX};
        py_off   = {2'b0, screenY} - {2'b0, BY};
        in_pf    = (screenX >= BX) && (px_off < PF_W) && (screenY >= BY) && (py_off < PF_H);
        cx       = 5'(px_off >> CELL_LOG2);
        cy       = 5'(py_off >> CELL_LOG2);
        rend_idx = IDX_W'(32'(cy) * GRID_W + 32'(cx));
        rend_cnt = in_pf ? cnt_q[rend_idx] : '0;

        r_d = 4'h0;
        g_d = 4'h0;
        b_d = 4'h0;
        if (restart) begin
            r_d = 4'h0;
        end else if (!in_pf) begin
            b_d = 4'hF;
        end else if ((cx == head_x_q) && (cy == head_y_q)) begin
            r_d = 4'hF;
            g_d = 4'hF;
            b_d = 4'hF;
        end else if (rend_cnt != '0) begin
            if (state_q == S_DEAD) r_d = 4'hF;
            else                   g_d = 4'hF;
        end else if (food_valid_q && (cx == food_x_q) && (cy == food_y_q)) begin
            r_d = 4'hF;
        end
    end

    always_ff @(posedge vga_clock) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < N; i++) cnt_q[i] <= (i == CENTER_IDX) ? INIT_LEN_V : '0;
            head_x_q     <= INIT_X;
            head_y_q     <= INIT_Y;
            dir_q        <= DIR_RIGHT;
            length_q     <= INIT_LEN_V;
            food_x_q     <= FOOD0_X;
            food_y_q     <= FOOD0_Y;
            food_valid_q <= 1'b1;
            score_q      <= 8'd0;
            eat_q        <= 1'b0;
            idx_q        <= '0;
            scan_cnt_q   <= '0;
            lfsr_q       <= 16'hACE1;
            r_q          <= 4'h0;
            g_q          <= 4'h0;
            b_q          <= 4'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            head_x_q     <= head_x_d;
            head_y_q     <= head_y_d;
            dir_q        <= dir_d;
            length_q     <= length_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            score_q      <= score_d;
            eat_q        <= eat_d;
            idx_q        <= idx_d;
            scan_cnt_q   <= scan_cnt_d;
            lfsr_q       <= lfsr_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
        end
    end

    assign r     = r_q;
    assign g     = g_q;
    assign b     = b_q;
    assign dead  = (state_q == S_DEAD);
    assign busy  = (state_q != S_IDLE) && (state_q != S_DEAD);
    assign score = score_q;

endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - directed self-checking bench for snake_engine
module tb_snake_engine;

    localparam int WHITE = 12'hFFF;
    localparam int GREEN = 12'h0F0;
    localparam int RED   = 12'hF00;
    localparam int BLUE  = 12'h00F;
    localparam int BLACK = 12'h000;

    localparam logic [3:0] B_NONE  = 4'b0000;
    localparam logic [3:0] B_UP    = 4'b1000;
    localparam logic [3:0] B_DOWN  = 4'b0100;
    localparam logic [3:0] B_LEFT  = 4'b0010;
    localparam logic [3:0] B_RIGHT = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n, tick, tick2;
    logic       up_in, down_in, left_in, right_in;
    logic [9:0] screenX;
    logic [8:0] screenY;
    logic [3:0] r, g, b, r2, g2, b2;
    logic       dead, busy, dead2, busy2;
    logic [7:0] score, score2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    snake_engine dut (
        .vga_clock(clk), .rst_n(rst_n), .tick(tick),
        .up_in(up_in), .down_in(down_in), .left_in(left_in), .right_in(right_in),
        .screenX(screenX), .screenY(screenY),
        .r(r), .g(g), .b(b), .dead(dead), .busy(busy), .score(score)
    );

    snake_engine #(.GRID_W(8), .GRID_H(6), .INIT_LEN(4)) dut2 (
        .vga_clock(clk), .rst_n(rst_n), .tick(tick2),
        .up_in(up_in), .down_in(down_in), .left_in(left_in), .right_in(right_in),
        .screenX(screenX), .screenY(screenY),
        .r(r2), .g(g2), .b(b2), .dead(dead2), .busy(busy2), .score(score2)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic do_step(input bit sel, input logic [3:0] btn, input int drop_at,
                           output int cycles, output logic dead_chk);
        @(negedge clk);
        {up_in, down_in, left_in, right_in} = btn;
        if (sel) tick2 = 1'b1;
        else     tick  = 1'b1;
        @(negedge clk);
        tick  = 1'b0;
        tick2 = 1'b0;
        {up_in, down_in, left_in, right_in} = B_NONE;
        dead_chk = sel ? dead2 : dead;
        cycles = 0;
        while ((sel ? busy2 : busy) && cycles < 2000) begin
            cycles++;
            tick = (!sel && cycles == drop_at);
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    task automatic probe_px(input bit sel, input int px, input int py, output int rgb);
        @(negedge clk);
        screenX = 10'(px);
        screenY = 9'(py);
        @(negedge clk);
        rgb = sel ? int'({r2, g2, b2}) : int'({r, g, b});
    endtask

    task automatic probe_cell(input bit sel, input int x, input int y, output int rgb);
        probe_px(sel, 80 + x * 16 + 8, 64 + y * 16 + 8, rgb);
    endtask

    task automatic pulse_tick(input logic [3:0] btn);
        @(negedge clk);
        {up_in, down_in, left_in, right_in} = btn;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        {up_in, down_in, left_in, right_in} = B_NONE;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c, cyc, bad, n_white, n_green, n_red;
        logic dc;

        rst_n = 1'b0; tick = 1'b0; tick2 = 1'b0;
        {up_in, down_in, left_in, right_in} = B_NONE;
        screenX = '0; screenY = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check_eq("reset_dead", int'(dead), 0);
        check_eq("reset_score", int'(score), 0);
        check_eq("reset_busy", int'(busy), 0);
        probe_cell(0, 15, 11, c); check_eq("reset_head_px", c, WHITE);
        probe_px(0, 10, 10, c);   check_eq("border_px", c, BLUE);
        probe_cell(0, 7, 5, c);   check_eq("reset_food_px", c, RED);
        probe_cell(0, 16, 11, c); check_eq("reset_empty_px", c, BLACK);

        // Length-4 snake closing a 2x2 loop onto its own tail survives
        do_step(1, B_RIGHT, 0, cyc, dc); check_eq("small_latency", cyc, 50);
        do_step(1, B_UP,    0, cyc, dc);
        do_step(1, B_LEFT,  0, cyc, dc);
        do_step(1, B_DOWN,  0, cyc, dc);
        check_eq("tail_chase_dead", int'(dead2), 0);
        check_eq("tail_chase_latency", cyc, 50);
        probe_cell(1, 4, 3, c); check_eq("tail_chase_head", c, WHITE);

        // First step with a second tick dropped mid-sweep
        do_step(0, B_NONE, 10, cyc, dc);
        check_eq("step_latency", cyc, 662);
        probe_cell(0, 16, 11, c); check_eq("step1_head", c, WHITE);
        probe_cell(0, 17, 11, c); check_eq("dropped_tick", c, BLACK);
        probe_cell(0, 15, 11, c); check_eq("step1_body", c, GREEN);

        // Length-5 snake in the same loop bites itself
        do_step(0, B_UP,   0, cyc, dc);
        do_step(0, B_LEFT, 0, cyc, dc);
        do_step(0, B_DOWN, 0, cyc, dc);
        check_eq("self_check_dead", int'(dc), 0);
        check_eq("self_dead", int'(dead), 1);
        check_eq("self_dead_busy_cycles", cyc, 1);
        probe_cell(0, 16, 11, c); check_eq("dead_body_red", c, RED);
        probe_cell(0, 15, 10, c); check_eq("dead_head", c, WHITE);

        pulse_tick(B_NONE);
        repeat (3) @(negedge clk);
        check_eq("dead_tick_no_btn", int'(dead), 1);

        // Restart from DEAD
        pulse_tick(B_UP);
        check_eq("restart_dead", int'(dead), 0);
        check_eq("restart_score", int'(score), 0);
        check_eq("restart_busy", int'(busy), 0);
        probe_cell(0, 15, 11, c); check_eq("restart_head", c, WHITE);
        probe_cell(0, 15, 10, c); check_eq("restart_cleared", c, BLACK);

        // Straight walk into the right wall
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            do_step(0, B_NONE, 0, cyc, dc);
            if (cyc != 662 || dead) bad++;
        end
        check_eq("wall_walk_steps", bad, 0);
        probe_cell(0, 29, 11, c); check_eq("wall_head_x29", c, WHITE);
        do_step(0, B_NONE, 0, cyc, dc);
        check_eq("wall_check_dead", int'(dc), 0);
        check_eq("wall_dead", int'(dead), 1);
        probe_cell(0, 28, 11, c); check_eq("wall_body_red", c, RED);

        // Restart with another button, then reversal reject
        pulse_tick(B_LEFT);
        check_eq("restart2_dead", int'(dead), 0);
        do_step(0, B_LEFT, 0, cyc, dc);
        probe_cell(0, 16, 11, c); check_eq("reverse_reject", c, WHITE);
        do_step(0, B_UP, 0, cyc, dc);
        probe_cell(0, 16, 10, c); check_eq("turn_up", c, WHITE);
        probe_cell(0, 16, 11, c); check_eq("turn_up_body", c, GREEN);

        // Walk onto the food at (7,5)
        do_step(0, B_LEFT, 0, cyc, dc);
        repeat (8) do_step(0, B_NONE, 0, cyc, dc);
        do_step(0, B_UP, 0, cyc, dc);
        repeat (3) do_step(0, B_NONE, 0, cyc, dc);
        check_eq("pre_eat_score", int'(score), 0);
        do_step(0, B_NONE, 0, cyc, dc);
        check_eq("eat_busy_through_food", int'(cyc > 662 && cyc <= 1322), 1);
        check_eq("eat_score", int'(score), 1);
        check_eq("eat_length", int'(dut.length_q), 6);
        check_eq("eat_head_cnt", int'(dut.cnt_q[5 * 30 + 7]), 6);
        n_white = 0; n_green = 0; n_red = 0;
        for (int y = 0; y < 22; y++) begin
            for (int x = 0; x < 30; x++) begin
                probe_cell(0, x, y, c);
                if (c == WHITE) n_white++;
                if (c == GREEN) n_green++;
                if (c == RED)   n_red++;
            end
        end
        check_eq("scan_white", n_white, 1);
        check_eq("scan_green", n_green, 4);
        check_eq("scan_food_on_empty", n_red, 1);

        // Reset during SWEEP
        pulse_tick(B_NONE);
        repeat (20) @(negedge clk);
        check_eq("midsweep_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_dead", int'(dead), 0);
        check_eq("rst_score", int'(score), 0);
        check_eq("rst_rgb", int'({r, g, b}), 0);
        check_eq("rst_length", int'(dut.length_q), 5);
        check_eq("rst_old_head_cnt", int'(dut.cnt_q[5 * 30 + 7]), 0);
        check_eq("rst_center_cnt", int'(dut.cnt_q[11 * 30 + 15]), 5);
        rst_n = 1'b1;
        probe_cell(0, 15, 11, c); check_eq("rst_head_px", c, WHITE);
        probe_cell(0, 7, 5, c);   check_eq("rst_food_px", c, RED);
        probe_cell(0, 7, 6, c);   check_eq("rst_cleared_px", c, BLACK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
